// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module   : fetch_unit_pkg
// Purpose  : Types and helpers shared between fetch and decode.
// Contents : fetch_entry_t - {pc, instr} pair carried through the fetch buffer
//            align_pc      - clears the two low address bits of a target
// Revision : 1.0 - initial release
// ============================================================================
`ifndef CONSTANTS_SV
`include "constants.sv"
`endif
`default_nettype none

package fetch_unit_pkg;

   typedef struct packed {
      logic [`XLEN-1:0]      pc;
      logic [`INSTR_LEN-1:0] instr;
   } fetch_entry_t;

   // Instructions are word aligned; stray low bits of a target are dropped.
   function automatic logic [`XLEN-1:0] align_pc(input logic [`XLEN-1:0] addr);
      return {addr[`XLEN-1:2], 2'b00};
   endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// ============================================================================
// Module   : fetch_unit_if
// Purpose  : Bundles the fetch stage's memory, redirect and decode signals.
// Ports    : imem_addr/imem_instr       - combinational instruction memory
//            redirect_valid/redirect_pc - control-flow change from execute
//            out_valid/out_ready        - handshake towards decode
//            out_instr/out_pc           - payload towards decode
// Modports : master - the fetch unit; slave - its environment
// Revision : 1.0 - initial release
// ============================================================================
`ifndef CONSTANTS_SV
`include "constants.sv"
`endif
`default_nettype none

interface fetch_unit_if;
   logic [`XLEN-1:0]      imem_addr;
   logic [`INSTR_LEN-1:0] imem_instr;
   logic                  redirect_valid;
   logic [`XLEN-1:0]      redirect_pc;
   logic                  out_valid;
   logic                  out_ready;
   logic [`INSTR_LEN-1:0] out_instr;
   logic [`XLEN-1:0]      out_pc;

   modport master (
      output imem_addr,
      input  imem_instr,
      input  redirect_valid,
      input  redirect_pc,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc
   );

   modport slave (
      input  imem_addr,
      output imem_instr,
      output redirect_valid,
      output redirect_pc,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc
   );
endinterface

`default_nettype wire

// File: rtl/constants.sv
// ============================================================================
// File     : constants.sv
// Purpose  : Machine-wide width and step constants shared by the front end.
// Contents : XLEN      - address / PC width in bits
//            INSTR_LEN - instruction word width in bits
//            PC_STEP   - byte distance between sequential instructions
// Revision : 1.0 - initial release
// ============================================================================
`ifndef CONSTANTS_SV
`define CONSTANTS_SV

`define XLEN      32
`define INSTR_LEN 32
`define PC_STEP   4

`endif

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Generic synchronous FIFO with flush; head visible combinationally
//            from registered storage.
// Ports    : clk, rst_n        - clock, async active-low reset
//            push, pop, flush  - write, read, clear (flush beats push)
//            wdata / rdata     - write data / head entry
//            count, full, empty- occupancy status
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int unsigned c_addr_w = $clog2(DEPTH);
   localparam int unsigned c_cnt_w  = $clog2(DEPTH+1);
   localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);

   logic [WIDTH-1:0]    r_mem [DEPTH];
   logic [c_addr_w-1:0] r_wr_ptr;
   logic [c_addr_w-1:0] r_rd_ptr;
   logic [c_cnt_w-1:0]  r_count;
   logic                w_push;
   logic                w_pop;

   // A push into a full FIFO is only legal when the head leaves the same cycle.
   assign w_pop  = pop & ~empty;
   assign w_push = push & (~full | w_pop);

   assign full  = (r_count == c_full_cnt);
   assign empty = (r_count == '0);
   assign count = r_count;
   assign rdata = r_mem[r_rd_ptr];

   // DEPTH is a power of two, so pointer wrap is the natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= '0;
         end
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage: owns the PC, reads the combinational
//            instruction memory, buffers {pc, instr} pairs for decode and
//            handles redirects from execute.
// Ports    : clk   - clock
//            rst_n - async active-low reset
//            bus   - fetch_unit_if.master (imem, redirect, decode handshake)
// Revision : 1.0 - initial release
// ============================================================================
`ifndef CONSTANTS_SV
`include "constants.sv"
`endif
`default_nettype none

module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [`XLEN-1:0] RESET_PC   = '0,
   parameter int unsigned      FIFO_DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_unit_if.master bus
);
   logic [`XLEN-1:0]                r_pc;
   fetch_entry_t                    w_wr_entry;
   fetch_entry_t                    w_rd_entry;
   logic                            w_push;
   logic                            w_pop;
   logic                            w_full;
   logic                            w_empty;
   logic [$clog2(FIFO_DEPTH+1)-1:0] w_count;
   logic                            w_unused;

   assign w_unused = &{1'b0, w_count};

   // A pop during a redirect is still a completed handshake; decode squashes it.
   assign w_pop  = bus.out_valid & bus.out_ready;
   // Fetch whenever a slot is free or is being freed this cycle.
   assign w_push = ~bus.redirect_valid & (~w_full | w_pop);

   assign w_wr_entry = '{pc: r_pc, instr: bus.imem_instr};

   fetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .pop   (w_pop),
      .flush (bus.redirect_valid),
      .wdata (w_wr_entry),
      .rdata (w_rd_entry),
      .count (w_count),
      .full  (w_full),
      .empty (w_empty)
   );

   // All outputs come from registers: no path from imem_instr or out_ready.
   assign bus.imem_addr = r_pc;
   assign bus.out_valid = ~w_empty;
   assign bus.out_instr = w_rd_entry.instr;
   assign bus.out_pc    = w_rd_entry.pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc <= RESET_PC;
      end else if (bus.redirect_valid) begin
         r_pc <= align_pc(bus.redirect_pc);
      end else if (w_push) begin
         r_pc <= r_pc + `XLEN'(`PC_STEP);
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit using a queue-based model of
//            the fetch buffer and directed plus randomized stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef CONSTANTS_SV
`include "constants.sv"
`endif
`default_nettype none

module tb_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fetch_unit_if bus ();

   // Memory word at byte address a is 0x1000_0000 + a/4.
   assign bus.imem_instr = 32'h1000_0000 + (bus.imem_addr >> 2);

   fetch_unit #(
      .RESET_PC   (RESET_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] m_pc;
   logic [31:0] m_q[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h1000_0000 + (a >> 2);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, ".valid"}, {31'd0, bus.out_valid}, 32'(m_q.size() != 0));
      check({tag, ".addr"}, bus.imem_addr, m_pc);
      if (m_q.size() != 0) begin
         check({tag, ".pc"}, bus.out_pc, m_q[0]);
         check({tag, ".instr"}, bus.out_instr, mem_word(m_q[0]));
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pc = RESET_PC;
   endtask

   // Check current outputs, apply inputs for one cycle, advance the model.
   task automatic tick(input logic rdy, input logic rv, input logic [31:0] rpc, input string tag);
      bit pop, push;
      check_state(tag);
      bus.out_ready      = rdy;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      pop = (m_q.size() != 0) && rdy;
      if (rv) begin
         m_q.delete();
         m_pc = rpc & 32'hFFFF_FFFC;
      end else begin
         push = (m_q.size() < DEPTH) || pop;
         if (pop) void'(m_q.pop_front());
         if (push) begin
            m_q.push_back(m_pc);
            m_pc = m_pc + 32'd4;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   // Assert reset between edges and check it takes effect before the next edge.
   task automatic async_reset(input string tag);
      bus.out_ready      = 1'b0;
      bus.redirect_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd0);
      check({tag, ".addr"}, bus.imem_addr, RESET_PC);
      check({tag, ".pc"}, bus.out_pc, 32'd0);
      check({tag, ".instr"}, bus.out_instr, 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bus.out_ready      = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      check("rst.valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst.instr", bus.out_instr, 32'd0);
      check("rst.pc", bus.out_pc, 32'd0);
      check("rst.addr", bus.imem_addr, RESET_PC);

      // Streaming from reset
      tick(1'b1, 1'b0, 32'd0, "stream");
      check("stream.first_pc", bus.out_pc, 32'h0);
      check("stream.first_instr", bus.out_instr, 32'h1000_0000);
      repeat (3) tick(1'b1, 1'b0, 32'd0, "stream");

      // Backpressure after reset: buffer fills, PC stalls
      async_reset("rst_a");
      repeat (5) tick(1'b0, 1'b0, 32'd0, "stall");
      check("stall.addr8", bus.imem_addr, 32'h8);
      check("stall.head0", bus.out_pc, 32'h0);

      // Single-cycle pop on a full buffer: simultaneous push and pop
      tick(1'b1, 1'b0, 32'd0, "fullpop");
      check("fullpop.head4", bus.out_pc, 32'h4);
      check("fullpop.addr12", bus.imem_addr, 32'hC);
      tick(1'b0, 1'b0, 32'd0, "hold");

      // Misaligned redirect while holding pcs 4 and 8
      tick(1'b0, 1'b1, 32'h0000_0203, "redir");
      check("redir.valid0", {31'd0, bus.out_valid}, 32'd0);
      check("redir.addr200", bus.imem_addr, 32'h200);
      tick(1'b1, 1'b0, 32'd0, "redir_t");
      check("redir.head200", bus.out_pc, 32'h200);
      repeat (3) tick(1'b1, 1'b0, 32'd0, "redir_s");

      // PC wrap-around
      tick(1'b1, 1'b1, 32'hFFFF_FFFC, "wrap");
      tick(1'b1, 1'b0, 32'd0, "wrap");
      check("wrap.pc_fffffffc", bus.out_pc, 32'hFFFF_FFFC);
      tick(1'b1, 1'b0, 32'd0, "wrap");
      check("wrap.pc_0", bus.out_pc, 32'h0);
      tick(1'b1, 1'b0, 32'd0, "wrap");
      check("wrap.pc_4", bus.out_pc, 32'h4);

      // Back-to-back redirects: last one wins
      tick(1'b1, 1'b1, 32'h0000_0040, "b2b");
      tick(1'b1, 1'b1, 32'h0000_0081, "b2b");
      check("b2b.valid0", {31'd0, bus.out_valid}, 32'd0);
      check("b2b.addr80", bus.imem_addr, 32'h80);
      repeat (2) tick(1'b1, 1'b0, 32'd0, "b2b_s");

      // Async reset with a full buffer, then restart
      repeat (3) tick(1'b0, 1'b0, 32'd0, "fill");
      async_reset("rst_b");
      repeat (3) tick(1'b1, 1'b0, 32'd0, "restart");

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic        rdy, rv;
         logic [31:0] rpc;
         rdy = ($urandom_range(0, 3) != 0);
         rv  = ($urandom_range(0, 11) == 0);
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : $urandom;
         tick(rdy, rv, rpc, "rnd");
      end
      check_state("final");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
